// File: rtl/write_merge_buf.sv
// Store write-merge buffer: gathers CPU stores into 16-byte lines and issues them one at a time.
// Optional idle-timeout eviction of the merge line is built when WBUF_TIMEOUT_EN is defined.
module write_merge_buf #(
   parameter int DEPTH = 4,
   parameter int TMO   = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_valid_i,
   output logic         st_ready_o,
   input  logic [31:0]  st_addr_i,
   input  logic [31:0]  st_wdata_i,
   input  logic [3:0]   st_strb_i,
   input  logic         flush_i,
   output logic         flush_done_o,
   output logic         wstart_rq_o,
   output logic [31:0]  win_addr_o,
   output logic [127:0] in_wdata_o,
   output logic [15:0]  in_mask_o,
   input  logic         finish_wresp_i,
   output logic         busy_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   logic         mergeValid_q, mergeValid_d;
   logic [27:0]  mergeTag_q, mergeTag_d;
   logic [127:0] mergeData_q, mergeData_d;
   logic [15:0]  mergeMask_q, mergeMask_d;

   logic [27:0]  fifoTag  [DEPTH];
   logic [127:0] fifoData [DEPTH];
   logic [15:0]  fifoMask [DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [AW:0]   fifoCount_q;

   state_t       state_q;
   logic         wstart_q;
   logic [31:0]  outAddr_q;
   logic [127:0] outData_q;
   logic [15:0]  outMask_q;
   logic         flushPend_q;

   logic fifoFull, tagHit, storeAcc, storeWr, missPush, linePush, tmoPush;
   logic pushEn, popEn, flushDone;
   logic unused_addrBits;

   assign unused_addrBits = ^st_addr_i[1:0];

   assign fifoFull  = (fifoCount_q == FULL_CNT);
   assign tagHit    = mergeValid_q && (mergeTag_q == st_addr_i[31:4]);
   assign st_ready_o = !flushPend_q && !(mergeValid_q && !tagHit && fifoFull);
   assign storeAcc  = st_valid_i && st_ready_o;
   assign storeWr   = storeAcc && (st_strb_i != 4'h0);
   assign missPush  = storeWr && mergeValid_q && !tagHit;
   assign linePush  = mergeValid_q && !fifoFull && (flushPend_q || tmoPush);
   assign pushEn    = missPush || linePush;
   assign popEn     = (state_q == WAIT) && finish_wresp_i;
   assign flushDone = flushPend_q && !mergeValid_q && (fifoCount_q == '0) && (state_q == IDLE);

   assign flush_done_o = flushDone;
   assign busy_o       = mergeValid_q || (fifoCount_q != '0) || (state_q != IDLE);
   assign wstart_rq_o  = wstart_q;
   assign win_addr_o   = outAddr_q;
   assign in_wdata_o   = outData_q;
   assign in_mask_o    = outMask_q;

`ifdef WBUF_TIMEOUT_EN
   logic [7:0] tmoCnt_q;

   // Evict the merge line on its TMO-th consecutive idle cycle.
   assign tmoPush = mergeValid_q && !fifoFull && !storeWr && (tmoCnt_q == 8'(TMO - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmoCnt_q <= '0;
      else if (storeWr || tmoPush || !mergeValid_q)
         tmoCnt_q <= '0;
      else if (tmoCnt_q != 8'(TMO - 1))
         tmoCnt_q <= tmoCnt_q + 8'd1;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TMO > 0);
   assign tmoPush    = 1'b0;
`endif

   // A miss reloads the line from scratch; a hit overlays only the enabled bytes.
   always_comb begin
      mergeValid_d = mergeValid_q;
      mergeTag_d   = mergeTag_q;
      mergeData_d  = mergeData_q;
      mergeMask_d  = mergeMask_q;
      if (linePush)
         mergeValid_d = 1'b0;
      if (storeWr) begin
         if (!tagHit) begin
            mergeValid_d = 1'b1;
            mergeTag_d   = st_addr_i[31:4];
            mergeData_d  = '0;
            mergeMask_d  = '0;
         end
         for (int i = 0; i < 16; i++) begin
            if ((i / 4) == int'(st_addr_i[3:2]) && st_strb_i[i % 4]) begin
               mergeData_d[8*i +: 8] = st_wdata_i[8*(i % 4) +: 8];
               mergeMask_d[i]        = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mergeValid_q <= 1'b0;
         mergeTag_q   <= '0;
         mergeData_q  <= '0;
         mergeMask_q  <= '0;
      end else begin
         mergeValid_q <= mergeValid_d;
         mergeTag_q   <= mergeTag_d;
         mergeData_q  <= mergeData_d;
         mergeMask_q  <= mergeMask_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pushEn) begin
         fifoTag[wrPtr_q]  <= mergeTag_q;
         fifoData[wrPtr_q] <= mergeData_q;
         fifoMask[wrPtr_q] <= mergeMask_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fifoCount_q <= '0;
      end else begin
         if (pushEn)
            wrPtr_q <= wrPtr_q + AW'(1);
         if (popEn)
            rdPtr_q <= rdPtr_q + AW'(1);
         if (pushEn && !popEn)
            fifoCount_q <= fifoCount_q + (AW+1)'(1);
         else if (popEn && !pushEn)
            fifoCount_q <= fifoCount_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flushPend_q <= 1'b0;
      else if (flushDone)
         flushPend_q <= 1'b0;
      else if (flush_i)
         flushPend_q <= 1'b1;
   end

   // Head entry is captured on leaving IDLE so the write channel sees it stable until the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wstart_q  <= 1'b0;
         outAddr_q <= '0;
         outData_q <= '0;
         outMask_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fifoCount_q != '0) begin
                  state_q   <= REQ;
                  wstart_q  <= 1'b1;
                  outAddr_q <= {fifoTag[rdPtr_q], 4'h0};
                  outData_q <= fifoData[rdPtr_q];
                  outMask_q <= fifoMask[rdPtr_q];
               end
            end
            REQ: begin
               state_q  <= WAIT;
               wstart_q <= 1'b0;
            end
            WAIT: begin
               if (finish_wresp_i)
                  state_q <= IDLE;
            end
            default: begin
               state_q  <= IDLE;
               wstart_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/write_merge_buf.md
WRITE_MERGE_BUF -- requirements
Module: write_merge_buf

Interface
REQ-001 Parameter DEPTH, default 4: issue FIFO entries; power of two, 2..16.
REQ-002 Parameter TMO, default 15: idle cycles before timeout flush, 1..255; used only with WBUF_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 st_valid  in  1  CPU store request.
REQ-006 st_ready  out  1  store accepted when st_valid&st_ready.
REQ-007 st_addr  in  32  store byte address.
REQ-008 st_wdata  in  32  store data.
REQ-009 st_strb  in  4  byte enables.
REQ-010 flush  in  1  one-cycle pulse; drain all buffered writes.
REQ-011 flush_done  out  1  one-cycle pulse when drain complete.
REQ-012 wstart_rq  out  1  one-cycle write start to write channel manager.
REQ-013 win_addr  out  32  line address, bits [3:0] always 0.
REQ-014 in_wdata  out  128  line data.
REQ-015 in_mask  out  16  line byte mask.
REQ-016 finish_wresp  in  1  one-cycle pulse: outstanding write completed.
REQ-017 busy  out  1  merge line valid, FIFO non-empty or FSM not IDLE.

Function
REQ-018 Merge register: valid, tag = addr[31:4], data 128, mask 16.
REQ-019 Lane placement: w = st_addr[3:2]; data to bits [32w+31:32w], strb to mask [4w+3:4w]; st_addr[1:0] ignored.
REQ-020 Accepted store with tag match on valid line: merge same cycle; enabled bytes overwrite, mask ORed.
REQ-021 Accepted store with merge empty: load line, other lanes' mask 0.
REQ-022 Accepted store with tag miss on valid line: push old line to FIFO, load new store, same cycle.
REQ-023 Store with st_strb=0: accepted, no state change, no allocation, no timeout restart.
REQ-024 st_ready = 0 when flush pending, or (merge valid, tag miss, FIFO full); else 1; FIFO full is registered state.
REQ-025 Issue FSM states IDLE, REQ, WAIT; IDLE->REQ when FIFO non-empty; REQ->WAIT unconditionally; WAIT->IDLE on finish_wresp, popping head.
REQ-026 wstart_rq = 1 exactly in REQ; win_addr/in_wdata/in_mask = FIFO head, stable REQ through WAIT.
REQ-027 One write outstanding; entry pushed in cycle N gives earliest wstart_rq in N+2.
REQ-028 finish_wresp outside WAIT ignored.
REQ-029 Push and pop in same cycle legal; count unchanged.
REQ-030 flush sets flush_pend; while set, valid merge line pushed when FIFO not full, merge then invalid.
REQ-031 flush_done asserted one cycle when flush_pend, merge empty, FIFO empty, FSM IDLE; flush_pend cleared same cycle.
REQ-032 flush with nothing buffered: flush_done in next cycle.
REQ-033 flush while flush_pend set: no additional effect.

Reset
REQ-034 On rst: merge invalid, FIFO empty, FSM IDLE, flush_pend 0, timeout counter 0.
REQ-035 During/after reset: wstart_rq, flush_done, busy 0; win_addr, in_wdata, in_mask 0; st_ready 1.
REQ-036 Reset mid-write discards all buffered data; no wstart_rq re-issue.

Configuration
REQ-037 Macro WBUF_TIMEOUT_EN defined: 8-bit counter cleared on each accepted store with nonzero strobe, increments while merge valid and no store; at TMO with FIFO not full, merge line pushed, counter cleared.
REQ-038 WBUF_TIMEOUT_EN undefined: no counter; merge line leaves only by tag miss or flush.

Verification
REQ-039 Stores 0x100/0x11111111/0xF, 0x104/0x22222222/0x3, then flush -> one wstart_rq, win_addr 0x100, in_mask 0x003F, in_wdata[47:0] 0x222211111111; after finish_wresp, flush_done.
REQ-040 Store 0x100 then 0x200, finish_wresp withheld -> wstart_rq for 0x100 only; 0x200 in merge; busy 1.
REQ-041 DEPTH=4, finish_wresp withheld, 6 stores to distinct lines -> st_ready 0 on 6th; each finish_wresp frees one entry and the stall clears.
REQ-042 Store to idle buffer with WBUF_TIMEOUT_EN, TMO=15 -> push on 15th idle cycle, wstart_rq 2 cycles later; without macro, no wstart_rq within 100 cycles.
REQ-043 rst asserted in WAIT with 3 entries buffered -> outputs 0 immediately, no wstart_rq after release, flush -> flush_done next cycle.
